// File: rtl/main_control_fsm_if.sv
// Control bus between the RV32 multicycle main control FSM (master) and the datapath (slave).
// Carries the opcode/memory handshake inputs and every datapath select and strobe.
interface main_control_fsm_if #(
  parameter int CNT_W = 16
) ();
  logic [6:0]       ir_opcode;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic             reg_write;
  logic             mem_to_reg;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_instr;

  modport master (
    input  ir_opcode, mem_ready,
    output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           pc_write, pc_write_cond, reg_write, mem_to_reg, instr_done,
           instr_count, illegal_instr
  );

  modport slave (
    output ir_opcode, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
           pc_write, pc_write_cond, reg_write, mem_to_reg, instr_done,
           instr_count, illegal_instr
  );
endinterface

// File: rtl/main_control_fsm.sv
// Moore main control FSM for the RV32 multicycle lab datapath with a retired-instruction counter.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of retiring as a NOP.
module main_control_fsm #(
  parameter logic [6:0] OP_R   = 7'b0110011,
  parameter logic [6:0] OP_LW  = 7'b0000011,
  parameter logic [6:0] OP_SW  = 7'b0100011,
  parameter logic [6:0] OP_BEQ = 7'b1100011,
  parameter int         CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  main_control_fsm_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd9;
`endif

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_instr_count;

  logic             w_op_r;
  logic             w_op_lw;
  logic             w_op_sw;
  logic             w_op_beq;
  logic             w_op_known;

  logic [1:0]       w_alu_op;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic             w_iord;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic             w_reg_write;
  logic             w_mem_to_reg;
  logic             w_instr_done;

  assign w_op_r     = (bus.ir_opcode == OP_R);
  assign w_op_lw    = (bus.ir_opcode == OP_LW);
  assign w_op_sw    = (bus.ir_opcode == OP_SW);
  assign w_op_beq   = (bus.ir_opcode == OP_BEQ);
  assign w_op_known = w_op_r | w_op_lw | w_op_sw | w_op_beq;

  // Next-state logic; mem_ready only matters in the three memory-wait states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op_lw || w_op_sw)  w_next = S_MEM_ADDR;
        else if (w_op_r)         w_next = S_EXEC_R;
        else if (w_op_beq)       w_next = S_BRANCH;
        else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: w_next = w_op_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Output decode; everything is forced low while rst is held so an aborted access leaves no strobe.
  always_comb begin
    w_alu_op        = 2'b00;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_instr_done    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = 2'b01;
          w_ir_write  = bus.mem_ready;
          w_pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          w_alu_src_b = 2'b10;
`ifndef ILLEGAL_TRAP_EN
          w_instr_done = ~w_op_known;
`endif
        end
        S_MEM_ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          w_mem_read = 1'b1;
          w_iord     = 1'b1;
        end
        S_MEM_WB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
          w_instr_done = 1'b1;
        end
        S_MEM_WR: begin
          w_mem_write  = 1'b1;
          w_iord       = 1'b1;
          w_instr_done = bus.mem_ready;
        end
        S_EXEC_R: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          w_reg_write  = 1'b1;
          w_instr_done = 1'b1;
        end
        S_BRANCH: begin
          w_alu_src_a     = 1'b1;
          w_alu_op        = 2'b01;
          w_pc_write_cond = 1'b1;
          w_instr_done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counter wraps silently at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_instr_count <= '0;
    else if (w_instr_done) r_instr_count <= r_instr_count + 1'b1;
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_op_known)  r_illegal <= 1'b1;
  end

  assign bus.illegal_instr = r_illegal;
`else
  assign bus.illegal_instr = 1'b0;
`endif

  assign bus.alu_op        = w_alu_op;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.reg_write     = w_reg_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.instr_done    = w_instr_done;
  assign bus.instr_count   = r_instr_count;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-instruction behavioural model (latency, strobe counts, counter)
// driven by randomized opcodes and memory wait states, plus directed reset and wrap steps.
module tb_main_control_fsm;

  localparam int TB_CNT_W = 4;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'h7F;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcc;
    logic       rw;
    logic       m2r;
    logic       done;
    logic       ill;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  main_control_fsm_if #(.CNT_W(TB_CNT_W)) bus ();

  main_control_fsm #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic smp_t sample();
    smp_t s;
    s = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.iord, bus.mem_read, bus.mem_write,
         bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.mem_to_reg,
         bus.instr_done, bus.illegal_instr};
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from FETCH entry to retirement with zero wait states.
  function automatic int base_len(input logic [6:0] op);
    if (op == OP_R)   return 4;
    if (op == OP_LW)  return 5;
    if (op == OP_SW)  return 4;
    if (op == OP_BEQ) return 3;
    return 2;
  endfunction

  // Run one instruction from FETCH entry; wf/wm are the stall cycles in fetch and data access.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
    smp_t s;
    smp_t hist[$];
    int   done_k, exp_len, mstart;
    int   nmrd, nmwr, nrw, nirw, npcw, npcc;
    bit   ismem, is_lw, is_sw;
    is_lw  = (op == OP_LW);
    is_sw  = (op == OP_SW);
    ismem  = is_lw || is_sw;
    mstart = wf + 3;
    done_k = -1;
    nmrd = 0; nmwr = 0; nrw = 0; nirw = 0; npcw = 0; npcc = 0;
    exp_len = base_len(op) + wf + (ismem ? wm : 0);
    for (int k = 0; k < 200; k++) begin
      bus.ir_opcode = op;
      if (k < wf)                                      bus.mem_ready = 1'b0;
      else if (k == wf)                                bus.mem_ready = 1'b1;
      else if (ismem && k >= mstart && k < mstart + wm) bus.mem_ready = 1'b0;
      else if (ismem && k == mstart + wm)              bus.mem_ready = 1'b1;
      else                                             bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      s = sample();
      hist.push_back(s);
      nmrd += int'(s.mrd); nmwr += int'(s.mwr); nrw += int'(s.rw);
      nirw += int'(s.irw); npcw += int'(s.pcw); npcc += int'(s.pcc);
      @(posedge clk);
      #1;
      if (s.done) begin
        done_k = k;
        break;
      end
    end
    model_cnt = (model_cnt + 1) % (1 << TB_CNT_W);
    check("retire_cycle", done_k, exp_len - 1);
    check("mem_read_cycles", nmrd, (wf + 1) + (is_lw ? wm + 1 : 0));
    check("mem_write_cycles", nmwr, is_sw ? wm + 1 : 0);
    check("reg_write_cycles", nrw, (op == OP_R || is_lw) ? 1 : 0);
    check("ir_write_cycles", nirw, 1);
    check("pc_write_cycles", npcw, 1);
    check("pc_write_cond_cycles", npcc, (op == OP_BEQ) ? 1 : 0);
    check("instr_count", bus.instr_count, model_cnt);
    if (done_k == exp_len - 1) begin
      check("fetch_sel", {hist[wf].iord, hist[wf].src_a, hist[wf].src_b, hist[wf].alu_op}, 6'b0_0_01_00);
      check("decode_sel", {hist[wf+1].src_a, hist[wf+1].src_b, hist[wf+1].alu_op}, 5'b0_10_00);
      if (op == OP_R)
        check("exec_r_sel", {hist[wf+2].alu_op, hist[wf+2].src_a, hist[wf+2].src_b}, 5'b10_1_00);
      if (op == OP_BEQ)
        check("branch_sel", {hist[wf+2].alu_op, hist[wf+2].src_b, hist[wf+2].pcc, hist[wf+2].pcw,
                             hist[wf+2].done}, 7'b01_00_1_0_1);
      if (ismem)
        check("mem_addr_sel", {hist[wf+2].alu_op, hist[wf+2].src_a, hist[wf+2].src_b, hist[wf+2].iord},
              6'b00_1_10_0);
      if (is_lw)
        check("mem_wb", {hist[done_k].rw, hist[done_k].m2r, hist[done_k-1].iord}, 3'b111);
      if (is_sw)
        check("mem_wr_done", {hist[done_k].mwr, hist[done_k].iord, hist[done_k].rw}, 3'b110);
    end
  endtask

  initial begin
    smp_t s;
    logic [6:0] op;
    int         pick;
    bus.ir_opcode = 7'h00;
    bus.mem_ready = 1'b0;

    // Reset state: everything quiet, counter clear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", sample(), 16'h0000);
    check("reset_count", bus.instr_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("fetch_after_reset", {bus.mem_read, bus.alu_src_b}, 3'b1_01);
    @(posedge clk);
    #1;

    // One of each class with zero waits, then the 3-wait load.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 1, 2);

    // Abort in the middle of a store.
    bus.ir_opcode = OP_SW;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mem_wr_before_abort", bus.mem_write, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_outputs", sample(), 16'h0000);
    check("abort_count", bus.instr_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    s = sample();
    check("after_abort_fetch", {s.mrd, s.mwr, s.iord, s.rw}, 4'b1000);
    check("after_abort_count", bus.instr_count, 0);
    model_cnt = 0;
    @(posedge clk);
    #1;

    // Sixteen R-type retirements wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_instr(OP_R, 0, 0);
    check("count_wrapped", bus.instr_count, 0);

    // Randomized instruction mix with random stalls and noise on mem_ready.
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
`ifdef ILLEGAL_TRAP_EN
        default: op = OP_R;
`else
        4: op = OP_BAD;
        default: op = 7'h13;
`endif
      endcase
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

`ifdef ILLEGAL_TRAP_EN
    // Unknown opcode locks into TRAP until reset.
    bus.ir_opcode = OP_BAD;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("decode_bad_no_done", bus.instr_done, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("trap_outputs", sample(), 16'h0001);
      check("trap_count", bus.instr_count, model_cnt);
    end
    rst = 1'b1;
    #1;
    check("trap_cleared", bus.illegal_instr, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 0;
    run_instr(OP_R, 0, 0);
`else
    run_instr(OP_BAD, 0, 0);
    run_instr(OP_BAD, 2, 0);
    check("illegal_tied_low", bus.illegal_instr, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
